serial_subtractor: RTL and testbench

// Multi-cycle, parametrised ripple-borrow subtractor: computes d = a - b - bin on WIDTH-bit operands.

---
 rtl/serial_subtractor_if.sv | 17 +
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done operand and result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, d, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, d, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle ripple-borrow subtractor, CHUNK bits per clock, LS chunk first
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);
  localparam int STEPS = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH ||
      (WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0) begin : g_bad_params
    $error("serial_subtractor: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic             brw_r;
  logic [CW-1:0]    cnt;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] diff_k;
  logic             brw_k;
  logic [WIDTH-1:0] res_nxt;
  logic             ovf_nxt;
  logic             last;

  always_comb begin
    base    = 32'(cnt) * 32'(CHUNK);
    a_k     = a_r[base +: CHUNK];
    b_k     = b_r[base +: CHUNK];
    // A CHUNK+1 bit difference goes negative exactly when a borrow leaves the chunk
    {brw_k, diff_k} = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, brw_r};
    res_nxt = res_r;
    res_nxt[base +: CHUNK] = diff_k;
    // Equals (borrow into MSB) ^ bout: overflow iff operand signs differ and result sign != a's sign
    ovf_nxt = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (a_r[WIDTH-1] ^ res_nxt[WIDTH-1]);
    last    = (cnt == CW'(STEPS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_r      <= '0;
      b_r      <= '0;
      res_r    <= '0;
      brw_r    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.d    <= '0;
      bus.bout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_RUN: begin
          res_r <= res_nxt;
          brw_r <= brw_k;
          cnt   <= cnt + CW'(1);
          if (last) begin
            bus.d    <= res_nxt;
            bus.bout <= brw_k;
            bus.ovf  <= ovf_nxt;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            brw_r    <= bus.bin;
            res_r    <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized and directed checks of serial_subtractor against an arithmetic model
`timescale 1ns/1ps
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(16)) m();
  serial_subtractor #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(m));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed {bout, ovf, d}, derived from plain integer arithmetic
  function automatic int model(input int w, input int a, input int b, input int bin);
    int diff, sa, sb, sd, lim;
    lim  = 1 << (w - 1);
    diff = a - b - bin;
    sa   = (a >= lim) ? a - (1 << w) : a;
    sb   = (b >= lim) ? b - (1 << w) : b;
    sd   = sa - sb - bin;
    return (int'(diff < 0) << 17) | (int'(sd < -lim || sd > lim - 1) << 16) | (diff & ((1 << w) - 1));
  endfunction

  function automatic int observed();
    return (int'(m.bout) << 17) | (int'(m.ovf) << 16) | int'(m.d);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input string tag, input bit noise);
    int lat, busy_n, exp_v;
    exp_v = model(16, int'(a), int'(b), int'(bin));
    @(negedge clk);
    m.a = a; m.b = b; m.bin = bin; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    lat = 0; busy_n = 0;
    while (!m.done && lat < 40) begin
      busy_n += int'(m.busy);
      if (noise) begin
        m.a = 16'($urandom); m.b = 16'($urandom);
        m.bin = 1'($urandom); m.start = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    m.start = 1'b0;
    check({tag, "_lat"}, lat, 4);
    check({tag, "_busy"}, busy_n, 4);
    check({tag, "_res"}, observed(), exp_v);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(m.done), 0);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_ex
    localparam int C  = 1 << gi;
    localparam int ST = 4 / C;
    logic rst_x;
    logic fin;
    serial_subtractor_if #(.WIDTH(4)) xb();
    serial_subtractor #(.WIDTH(4), .CHUNK(C)) u_x (.clk(clk), .rst(rst_x), .bus(xb));

    initial begin
      int lat, exp_v, got_v;
      fin = 1'b0; rst_x = 1'b1;
      xb.start = 1'b0; xb.a = '0; xb.b = '0; xb.bin = 1'b0;
      repeat (2) @(negedge clk);
      rst_x = 1'b0;
      for (int v = 0; v < 512; v++) begin
        @(negedge clk);
        xb.a = 4'(v); xb.b = 4'(v >> 4); xb.bin = 1'(v >> 8); xb.start = 1'b1;
        @(negedge clk);
        xb.start = 1'b0;
        xb.a = 4'($urandom); xb.b = 4'($urandom); xb.bin = 1'($urandom);
        lat = 0;
        while (!xb.done && lat < 20) begin
          @(negedge clk);
          lat++;
        end
        exp_v = (ST << 24) | model(4, v & 15, (v >> 4) & 15, (v >> 8) & 1);
        got_v = (lat << 24) | (int'(xb.bout) << 17) | (int'(xb.ovf) << 16) | int'(xb.d);
        check($sformatf("exh_c%0d_v%0d", C, v), got_v, exp_v);
      end
      fin = 1'b1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, done_n;
    rst = 1'b1;
    m.start = 1'b0; m.a = '0; m.b = '0; m.bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {m.busy, m.done, m.bout, m.ovf, m.d}, 0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0234, 1'b0, "c1", 1'b0);
    check("c1_const", observed(), 32'h0_1000);
    run_op(16'h0000, 16'h0001, 1'b0, "c2a", 1'b0);
    check("c2a_const", observed(), 32'h2_FFFF);
    run_op(16'h0000, 16'h0000, 1'b1, "c2b", 1'b0);
    check("c2b_const", observed(), 32'h2_FFFF);
    run_op(16'h8000, 16'h0001, 1'b0, "c3a", 1'b0);
    check("c3a_const", observed(), 32'h1_7FFF);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, "c3b", 1'b0);
    check("c3b_const", observed(), 32'h3_8000);

    // Start while busy is ignored, then a back-to-back start from the DONE cycle
    @(negedge clk);
    m.a = 16'h1234; m.b = 16'h0234; m.bin = 1'b0; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0; lat = 0; done_n = 0;
    @(negedge clk); lat++;
    m.a = 16'hFFFF; m.b = 16'h0001; m.bin = 1'b1; m.start = 1'b1;
    @(negedge clk); lat++;
    m.start = 1'b0;
    while (!m.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("c4_lat", lat, 4);
    check("c4_res", observed(), 32'h0_1000);
    m.a = 16'h00FF; m.b = 16'h0F00; m.bin = 1'b1; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0; lat = 0;
    check("c4_single_done", 32'(m.done), 0);
    while (!m.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("c4_b2b_lat", lat, 4);
    check("c4_b2b_res", observed(), model(16, 'h00FF, 'h0F00, 1));

    // Reset in the middle of an operation
    @(negedge clk);
    m.a = 16'hFFFF; m.b = 16'h0000; m.bin = 1'b0; m.start = 1'b1;
    @(negedge clk);
    m.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("c5_rst_outputs", {m.busy, m.done, m.bout, m.ovf, m.d}, 0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    repeat (10) begin
      @(negedge clk);
      done_n += int'(m.done) + int'(m.busy);
    end
    check("c5_no_done", done_n, 0);

    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rnd%0d", i), 1'b1);
    end

    lat = 0;
    while (!(g_ex[0].fin && g_ex[1].fin && g_ex[2].fin) && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    check("exh_finished", {31'd0, g_ex[0].fin && g_ex[1].fin && g_ex[2].fin}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
